multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, 4, opcode field width; legal range 4..8.
REQ-002 Parameter ALU_OP_W, 2, ALU operation select width; legal range 2..4.
REQ-003 Parameter CNT_W, 16, retired-instruction counter width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port opcode  input  OPCODE_W  opcode field of the instruction bus; sampled only when ir_write=1.
REQ-007 Port zero  input  1  ALU zero flag; used for BEQ.
REQ-008 Port mem_ready  input  1  memory done; completes the current instruction fetch or data access.
REQ-009 Port stall  input  1  freezes the FSM and the counter while high.
REQ-010 Ports pc_write, pc_src, ir_write, mem_read, mem_write, reg_dst, mem_to_reg, reg_write, load  output  1 each  datapath strobes.
REQ-011 Port alu_op  output  ALU_OP_W  ALU select; 0 = add, 1 = subtract, 2 = address add; upper bits 0.
REQ-012 Port illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-013 Port instr_count  output  CNT_W  retired-instruction count.
REQ-014 Port state  output  3  current FSM state, for debug.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB.
- All outputs are Moore outputs decoded from the registered state and the latched opcode.
REQ-016 IDLE: all strobes 0; next state is always FETCH.
REQ-017 FETCH: mem_read=1.
- mem_ready=0: stay in FETCH.
- mem_ready=1: ir_write=1, pc_write=1, pc_src=0, latch opcode; next state DECODE.
REQ-018 DECODE: all strobes 0; next state EXEC.
- Undefined opcode: illegal=1 for this cycle; next state FETCH; no register or memory write occurs.
REQ-019 Opcode map: 0 LW, 1 SW, 2 ADD, 3 SUB, 4 LOADC, 5 BEQ; every other value is undefined.
REQ-020 EXEC by opcode:
- LW/SW: alu_op=2; next state MEM.
- ADD: alu_op=0, reg_dst=1; next state WB.
- SUB: alu_op=1, reg_dst=1; next state WB.
- LOADC: load=1; next state WB.
- BEQ: alu_op=1; pc_write=1 and pc_src=1 only if zero=1; next state FETCH.
REQ-021 MEM:
- LW: mem_read=1 held until mem_ready=1, then next state WB.
- SW: mem_write=1 held until mem_ready=1, then next state FETCH.
REQ-022 WB: reg_write=1 for exactly one cycle.
- LW: mem_to_reg=1.
- ADD/SUB: reg_dst=1.
- LOADC: load=1.
- Next state FETCH.
REQ-023 While stall=1:
- State, latched opcode and instr_count hold.
- Every write strobe (pc_write, ir_write, reg_write, mem_write) is forced to 0.
- mem_read keeps its state-decoded value.
REQ-024 stall has priority over mem_ready: a mem_ready arriving in a stalled cycle is ignored.
REQ-025 instr_count SHALL increment by 1 on each transition to FETCH from EXEC (BEQ), MEM (SW) or WB.
- It does not increment on an illegal opcode.
- It wraps modulo 2^CNT_W.
REQ-026 Latency with mem_ready always high:
- BEQ: 3 cycles.
- ADD, SUB, LOADC, SW: 4 cycles.
- LW: 5 cycles.

Reset
REQ-027 While reset=1: state=IDLE, latched opcode=0, instr_count=0, all strobes 0, alu_op=0, illegal=0, independent of clk.
REQ-028 A reset asserted mid-instruction SHALL abort it immediately; no partial write strobe survives past the reset edge.
REQ-029 The first FETCH SHALL occur in the second rising edge after reset deasserts.

Structure
REQ-030 Shared package SHALL hold the state enumeration, the opcode constants and the alu_op encodings.
REQ-031 The opcode-to-class decode (load, store, alu, loadc, branch, undefined) SHALL be a combinational sub-module, opcode_decoder, parametrised by OPCODE_W.

Verification
REQ-032 Reset, then ADD (2) with mem_ready=1 -> ir_write at cycle 2, reg_write=1 with reg_dst=1 at cycle 5, instr_count=1.
REQ-033 LW (0) with mem_ready low for 3 MEM cycles -> mem_read held for 4 cycles, then one WB cycle with mem_to_reg=1.
REQ-034 BEQ (5) with zero=1, then BEQ with zero=0 -> pc_src=1 with pc_write in the first EXEC; no pc_write in the second EXEC.
REQ-035 Opcode 4'hF -> illegal pulses for 1 cycle, no reg_write or mem_write, instr_count unchanged.
REQ-036 stall=1 for 5 cycles during MEM of SW, with mem_ready=1 -> state holds, mem_write=0; SW completes one cycle after stall drops.
REQ-037 reset asserted during WB, and CNT_W=2 after 4 retirements -> reg_write drops asynchronously; counter reads 0 in both cases (reset, and wrap after 4).

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_t     : controller FSM states (value is also the debug 'state' code)
//   op_class_t  : instruction classes produced by opcode_decoder
//   OP_*        : opcode values
//   ALU_*       : alu_op encodings
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD   = 3'd0,
      CLS_STORE  = 3'd1,
      CLS_ALU    = 3'd2,
      CLS_LOADC  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_UNDEF  = 3'd5
   } op_class_t;

   // Opcode values, kept 8 bits wide (the widest legal opcode field).
   localparam logic [7:0] OP_LW    = 8'd0;
   localparam logic [7:0] OP_SW    = 8'd1;
   localparam logic [7:0] OP_ADD   = 8'd2;
   localparam logic [7:0] OP_SUB   = 8'd3;
   localparam logic [7:0] OP_LOADC = 8'd4;
   localparam logic [7:0] OP_BEQ   = 8'd5;

   // ALU select codes; wider alu_op ports zero-extend these.
   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_SUB  = 2'd1;
   localparam logic [1:0] ALU_ADDR = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// opcode_decoder: combinational opcode-to-class decode.
//   opcode   in  : latched opcode field (OPCODE_W bits)
//   op_class out : load / store / alu / loadc / branch / undefined
//   is_sub   out : within the alu class, selects subtract instead of add
module opcode_decoder
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class,
   output logic                is_sub
);

   always_comb begin
      op_class = CLS_UNDEF;
      is_sub   = 1'b0;
      if (opcode == OPCODE_W'(OP_LW)) begin
         op_class = CLS_LOAD;
      end else if (opcode == OPCODE_W'(OP_SW)) begin
         op_class = CLS_STORE;
      end else if (opcode == OPCODE_W'(OP_ADD)) begin
         op_class = CLS_ALU;
      end else if (opcode == OPCODE_W'(OP_SUB)) begin
         op_class = CLS_ALU;
         is_sub   = 1'b1;
      end else if (opcode == OPCODE_W'(OP_LOADC)) begin
         op_class = CLS_LOADC;
      end else if (opcode == OPCODE_W'(OP_BEQ)) begin
         op_class = CLS_BRANCH;
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for a
// multicycle datapath, with a retired-instruction counter.
//   clk, reset (async, active-high)
//   opcode      in  : instruction opcode field, captured on ir_write
//   zero        in  : ALU zero flag (BEQ condition)
//   mem_ready   in  : completes the pending fetch / data access
//   stall       in  : freezes state, opcode latch and counter; kills writes
//   pc_write, pc_src, ir_write, mem_read, mem_write, reg_dst, mem_to_reg,
//   reg_write, load out : datapath strobes
//   alu_op      out : 0 add, 1 subtract, 2 address add
//   illegal     out : high in DECODE for an undefined opcode
//   instr_count out : retired-instruction count (wraps)
//   state       out : current FSM state code
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned ALU_OP_W = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                stall,
   output logic                pc_write,
   output logic                pc_src,
   output logic                ir_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                load,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal,
   output logic [CNT_W-1:0]    instr_count,
   output logic [2:0]          state
);

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   op_class_t           op_class;
   logic                is_sub;
   logic                cnt_inc;

   opcode_decoder #(
      .OPCODE_W (OPCODE_W)
   ) u_dec (
      .opcode   (op_q),
      .op_class (op_class),
      .is_sub   (is_sub)
   );

   assign state = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         // ir_write is already suppressed while stalled
         if (ir_write) op_q <= opcode;
         if (cnt_inc)  instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      load       = 1'b0;
      illegal    = 1'b0;
      alu_op     = '0;
      cnt_inc    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (op_class == CLS_UNDEF) begin
               illegal = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (op_class)
               CLS_LOAD, CLS_STORE: begin
                  alu_op  = ALU_OP_W'(ALU_ADDR);
                  state_d = ST_MEM;
               end
               CLS_ALU: begin
                  alu_op  = is_sub ? ALU_OP_W'(ALU_SUB) : ALU_OP_W'(ALU_ADD);
                  reg_dst = 1'b1;
                  state_d = ST_WB;
               end
               CLS_LOADC: begin
                  load    = 1'b1;
                  state_d = ST_WB;
               end
               CLS_BRANCH: begin
                  alu_op   = ALU_OP_W'(ALU_SUB);
                  pc_write = zero;
                  pc_src   = zero;
                  state_d  = ST_FETCH;
                  cnt_inc  = 1'b1;
               end
               default: begin
                  state_d = ST_FETCH;
               end
            endcase
         end

         ST_MEM: begin
            if (op_class == CLS_LOAD) begin
               mem_read = 1'b1;
               if (mem_ready) state_d = ST_WB;
            end else begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  state_d = ST_FETCH;
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_class == CLS_LOAD);
            reg_dst    = (op_class == CLS_ALU);
            load       = (op_class == CLS_LOADC);
            state_d    = ST_FETCH;
            cnt_inc    = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Stall overrides everything above, including a coincident mem_ready;
      // mem_read and the other non-write outputs keep their decoded values.
      if (stall) begin
         state_d   = state_q;
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         cnt_inc   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (CNT_W=2 so the counter
// wraps after four retirements, ALU_OP_W=3 to exercise zero upper bits).
module tb_multicycle_control_unit;

   localparam int unsigned OW = 4;
   localparam int unsigned AW = 3;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          reset, zero, mem_ready, stall;
   logic [OW-1:0] opcode;
   logic          pc_write, pc_src, ir_write, mem_read, mem_write;
   logic          reg_dst, mem_to_reg, reg_write, load, illegal;
   logic [AW-1:0] alu_op;
   logic [CW-1:0] instr_count;
   logic [2:0]    state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(
      .OPCODE_W (OW),
      .ALU_OP_W (AW),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .stall       (stall),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .ir_write    (ir_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .load        (load),
      .alu_op      (alu_op),
      .illegal     (illegal),
      .instr_count (instr_count),
      .state       (state)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic pc_write, pc_src, ir_write, mem_read, mem_write;
      logic reg_dst, mem_to_reg, reg_write, load, illegal;
      logic [AW-1:0] alu_op;
   } outs_t;

   typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB} phase_e;

   phase_e      plan[$];   // remaining phases of the current instruction
   int unsigned m_op  = 0;
   int unsigned m_cnt = 0;

   function automatic outs_t expect_outs(phase_e ph, int unsigned op,
                                         logic z, logic rdy, logic stl);
      outs_t e;
      e = '0;
      case (ph)
         P_FETCH: begin
            e.mem_read = 1'b1;
            if (rdy) begin
               e.ir_write = 1'b1;
               e.pc_write = 1'b1;
            end
         end
         P_DECODE: e.illegal = (op > 5);
         P_EXEC: begin
            case (op)
               0, 1: e.alu_op = 3'd2;
               2: begin e.alu_op = 3'd0; e.reg_dst = 1'b1; end
               3: begin e.alu_op = 3'd1; e.reg_dst = 1'b1; end
               4: e.load = 1'b1;
               5: begin e.alu_op = 3'd1; e.pc_write = z; e.pc_src = z; end
               default: ;
            endcase
         end
         P_MEM: begin
            if (op == 0) e.mem_read  = 1'b1;
            else         e.mem_write = 1'b1;
         end
         P_WB: begin
            e.reg_write  = 1'b1;
            e.mem_to_reg = (op == 0);
            e.reg_dst    = (op == 2 || op == 3);
            e.load       = (op == 4);
         end
         default: ;
      endcase
      if (stl) begin
         e.pc_write  = 1'b0;
         e.ir_write  = 1'b0;
         e.reg_write = 1'b0;
         e.mem_write = 1'b0;
      end
      return e;
   endfunction

   // Single compare process: checks every cycle, then advances the model.
   always @(negedge clk) begin
      outs_t         got, exp;
      logic [CW-1:0] exp_cnt;
      phase_e        cur;
      got = {pc_write, pc_src, ir_write, mem_read, mem_write,
             reg_dst, mem_to_reg, reg_write, load, illegal, alu_op};
      if (reset) begin
         plan.delete();
         plan.push_back(P_IDLE);
         m_op  = 0;
         m_cnt = 0;
         exp   = '0;
      end else begin
         exp = expect_outs(plan[0], m_op, zero, mem_ready, stall);
      end
      exp_cnt = m_cnt[CW-1:0];

      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL outputs t=%0t: dut=%b model=%b (pcw,pcs,irw,mr,mw,rd,m2r,rw,ld,ill,alu)",
                  $time, got, exp);
      end
      n_checks++;
      if (instr_count !== exp_cnt) begin
         n_fail++;
         $display("FAIL instr_count t=%0t: dut=%0d model=%0d", $time, instr_count, exp_cnt);
      end

      if (!reset && !stall) begin
         cur = plan.pop_front();
         case (cur)
            P_FETCH: begin
               if (mem_ready) begin
                  m_op = opcode;
                  plan.push_back(P_DECODE);
                  if (m_op <= 5) plan.push_back(P_EXEC);
                  if (m_op <= 1) plan.push_back(P_MEM);
                  if (m_op == 0 || (m_op >= 2 && m_op <= 4)) plan.push_back(P_WB);
               end else begin
                  plan.push_front(P_FETCH);
               end
            end
            P_MEM: if (!mem_ready) plan.push_front(P_MEM);
            default: ;
         endcase
         if (plan.size() == 0) begin
            if (cur != P_IDLE && m_op <= 5) m_cnt++;
            plan.push_back(P_FETCH);
         end
      end
   end

   // ---------------- directed stimulus with literal checks ----------------
   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b1; opcode = 4'd2; zero = 1'b0; mem_ready = 1'b1; stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 1;
      @(negedge clk);
      lit("idle_ir_write", ir_write, 0);
      lit("reset_count", instr_count, 0);
      adv(1);                                   // c2 FETCH ADD
      @(negedge clk);
      lit("add_ir_write", ir_write, 1);
      lit("add_fetch_pc_write", pc_write, 1);
      adv(3);                                   // c5 WB
      @(negedge clk);
      lit("add_reg_write", reg_write, 1);
      lit("add_reg_dst", reg_dst, 1);
      adv(1); opcode = 4'd0;                    // c6 FETCH LW
      @(negedge clk);
      lit("add_count", instr_count, 1);
      adv(3); mem_ready = 1'b0;                 // c9 first MEM cycle
      @(negedge clk); lit("lw_mem_read_1", mem_read, 1);
      adv(1); @(negedge clk); lit("lw_mem_read_2", mem_read, 1);
      adv(1); @(negedge clk); lit("lw_mem_read_3", mem_read, 1);
      adv(1); mem_ready = 1'b1;                 // c12
      @(negedge clk); lit("lw_mem_read_4", mem_read, 1);
      adv(1);                                   // c13 WB
      @(negedge clk);
      lit("lw_reg_write", reg_write, 1);
      lit("lw_mem_to_reg", mem_to_reg, 1);
      adv(1); opcode = 4'd5; zero = 1'b1;       // c14 FETCH BEQ
      @(negedge clk);
      lit("lw_wb_one_cycle", reg_write, 0);
      lit("lw_count", instr_count, 2);
      adv(2);                                   // c16 EXEC
      @(negedge clk);
      lit("beq_taken_pc_write", pc_write, 1);
      lit("beq_taken_pc_src", pc_src, 1);
      lit("beq_alu_op", alu_op, 1);
      adv(1); zero = 1'b0;                      // c17 FETCH BEQ
      @(negedge clk); lit("beq_count", instr_count, 3);
      adv(2);                                   // c19 EXEC
      @(negedge clk); lit("beq_not_taken_pc_write", pc_write, 0);
      adv(1); opcode = 4'hF;                    // c20 FETCH illegal
      @(negedge clk); lit("count_wrap", instr_count, 0);
      adv(1);                                   // c21 DECODE
      @(negedge clk); lit("illegal_pulse", illegal, 1);
      adv(1); opcode = 4'd1;                    // c22 FETCH SW
      @(negedge clk);
      lit("illegal_one_cycle", illegal, 0);
      lit("illegal_count", instr_count, 0);
      adv(3); stall = 1'b1;                     // c25 MEM, stalled
      @(negedge clk); lit("sw_stall_mem_write_0", mem_write, 0);
      for (int k = 1; k < 5; k++) begin
         adv(1);
         @(negedge clk); lit("sw_stall_mem_write", mem_write, 0);
      end
      adv(1); stall = 1'b0;                     // c30
      @(negedge clk); lit("sw_mem_write", mem_write, 1);
      adv(1); opcode = 4'd3;                    // c31 FETCH SUB
      @(negedge clk);
      lit("sw_count", instr_count, 1);
      lit("sw_then_fetch", mem_read, 1);
      adv(2);                                   // c33 EXEC SUB
      @(negedge clk);
      lit("sub_alu_op", alu_op, 1);
      lit("sub_reg_dst", reg_dst, 1);
      adv(2); opcode = 4'd4;                    // c35 FETCH LOADC
      @(negedge clk); lit("sub_count", instr_count, 2);
      adv(2);                                   // c37 EXEC LOADC
      @(negedge clk); lit("loadc_exec_load", load, 1);
      adv(1);                                   // c38 WB
      @(negedge clk);
      lit("loadc_wb_load", load, 1);
      lit("loadc_wb_reg_write", reg_write, 1);
      adv(1); opcode = 4'd2; stall = 1'b1;      // c39 FETCH stalled
      @(negedge clk);
      lit("stall_fetch_ir_write", ir_write, 0);
      lit("stall_fetch_mem_read", mem_read, 1);
      adv(1);
      @(negedge clk); lit("stall_fetch_ir_write_2", ir_write, 0);
      adv(1); stall = 1'b0;                     // c41
      @(negedge clk);
      lit("fetch_after_stall", ir_write, 1);
      lit("loadc_count", instr_count, 3);
      adv(3);                                   // c44 WB ADD
      @(negedge clk);
      lit("pre_reset_reg_write", reg_write, 1);
      #2 reset = 1'b1;
      #1;
      lit("async_reset_reg_write", reg_write, 0);
      lit("async_reset_count", instr_count, 0);
      lit("async_reset_mem_read", mem_read, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int n = 0; n < 300; n++) begin
         adv(1);
         opcode    = OW'($urandom_range(0, 15));
         mem_ready = ($urandom_range(0, 9) < 7);
         stall     = ($urandom_range(0, 9) < 2);
         zero      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
